// File: rtl/alu2_pkg.sv
// alu2_pkg: op codes, operand-size/state types and size helper for alu2_seq.
package alu2_pkg;
  typedef enum logic [3:0] {
    ALU2_PASS1 = 4'b0000, ALU2_PASS2 = 4'b0001, ALU2_EIP  = 4'b0010, ALU2_POP = 4'b0100,
    ALU2_STR   = 4'b0101, ALU2_PUSH  = 4'b0110, ALU2_RETI = 4'b1000, ALU2_REP = 4'b1001
  } alu2_op_e;
  localparam logic [3:0] OP_PASS1 = 4'b0000;
  localparam logic [3:0] OP_PASS2 = 4'b0001;
  localparam logic [3:0] OP_EIP   = 4'b0010;
  localparam logic [3:0] OP_POP   = 4'b0100;
  localparam logic [3:0] OP_STR   = 4'b0101;
  localparam logic [3:0] OP_PUSH  = 4'b0110;
  localparam logic [3:0] OP_RETI  = 4'b1000;
  localparam logic [3:0] OP_REP   = 4'b1001;
  typedef enum logic [1:0] {SZ_1 = 2'b00, SZ_2 = 2'b01, SZ_4 = 2'b10, SZ_4B = 2'b11} op_size_e;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REP = 1'b1} alu2_st_e;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REP  = 1'b1;
  function automatic logic [2:0] size_bytes(input logic [1:0] op_size);
    return op_size == 2'b00 ? 3'd1 : op_size == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/alu2_ptr_step.sv
// alu2_ptr_step: steps a pointer by the operand size, down when df is set.
module alu2_ptr_step
  import alu2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ptr,
  input  logic              df,
  input  logic [1:0]        op_size,
  output logic [DATA_W-1:0] res
);
  logic [DATA_W-1:0] sz;
  assign sz = DATA_W'(size_bytes(op_size));
  assign res = df ? ptr - sz : ptr + sz;
endmodule

// File: rtl/alu2_seq.sv
// alu2_seq: registered execute-stage ALU2 with valid/ready handshakes.
// Define ALU2_REP_EN to compile in the REP string sequencer (op 1001).
module alu2_seq
  import alu2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu2_op,
  input  logic [1:0]        op_size,
  input  logic              DF_in,
  input  logic [DATA_W-1:0] sr1,
  input  logic [DATA_W-1:0] sr2,
  input  logic [DATA_W-1:0] esp,
  input  logic [DATA_W-1:0] EIP_next,
  input  logic [CNT_W-1:0]  ecx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_res2,
  output logic [DATA_W-1:0] alu_res2_b,
  output logic [CNT_W-1:0]  ecx_out,
  output logic              out_last,
  output logic              out_nop,
  output logic              out_err
);
  logic [0:0] state;
  logic busy, accept, rep_df, n_last, n_nop, n_rep, n_err;
  logic [1:0] rep_size;
  logic [DATA_W-1:0] sz, step_a, step_b, n_res, n_b;
  logic [CNT_W-1:0] n_cnt;
  assign busy = state == ST_REP;
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept = in_valid && in_ready && !flush;
  assign sz = DATA_W'(size_bytes(op_size));
  // While iterating, the steppers walk the registered pointers of the last beat.
  alu2_ptr_step #(.DATA_W(DATA_W)) u_step_a (
    .ptr(busy ? alu_res2 : sr2), .df(busy ? rep_df : DF_in),
    .op_size(busy ? rep_size : op_size), .res(step_a)
  );
  alu2_ptr_step #(.DATA_W(DATA_W)) u_step_b (
    .ptr(busy ? alu_res2_b : sr1), .df(busy ? rep_df : DF_in),
    .op_size(busy ? rep_size : op_size), .res(step_b)
  );
  always_comb begin
    n_res = '0;
    n_b = '0;
    n_cnt = '0;
    n_last = 1'b1;
    n_nop = 1'b0;
    n_rep = 1'b0;
    n_err = 1'b0;
    case (alu2_op)
      OP_PASS1: n_res = sr1;
      OP_PASS2: n_res = sr2;
      OP_EIP:   n_res = EIP_next;
      OP_POP:   n_res = esp + sz;
      OP_STR:   n_res = step_a;
      OP_PUSH:  n_res = esp - sz;
      OP_RETI:  n_res = esp + DATA_W'(4) + sr2;
`ifdef ALU2_REP_EN
      OP_REP: begin
        n_nop = ecx == '0;
        n_res = n_nop ? sr2 : step_a;
        n_b = n_nop ? sr1 : step_b;
        n_cnt = n_nop ? '0 : ecx - CNT_W'(1);
        n_last = ecx <= CNT_W'(1);
        n_rep = !n_last;
      end
`endif
      default:  n_err = 1'b1;
    endcase
  end
`ifndef ALU2_REP_EN
  logic unused_ecx;
  assign unused_ecx = ^ecx;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      out_valid <= 1'b0;
      alu_res2 <= '0;
      alu_res2_b <= '0;
      ecx_out <= '0;
      out_last <= 1'b0;
      out_nop <= 1'b0;
      out_err <= 1'b0;
      rep_df <= 1'b0;
      rep_size <= 2'b00;
    end else if (flush) begin
      state <= ST_IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      state <= n_rep ? ST_REP : ST_IDLE;
      out_valid <= 1'b1;
      alu_res2 <= n_res;
      alu_res2_b <= n_b;
      ecx_out <= n_cnt;
      out_last <= n_last;
      out_nop <= n_nop;
      out_err <= n_err;
      rep_df <= DF_in;
      rep_size <= op_size;
    end else if (out_valid && out_ready) begin
      if (busy && !out_last) begin
        alu_res2 <= step_a;
        alu_res2_b <= step_b;
        ecx_out <= ecx_out - CNT_W'(1);
        out_last <= ecx_out == CNT_W'(1);
      end else begin
        state <= ST_IDLE;
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu2_seq.sv
// tb_alu2_seq: table-driven vectors plus REP/flush/reset sequences, scoreboard-checked.
module tb_alu2_seq;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, df = 1'b0;
  logic [3:0] alu2_op = '0;
  logic [1:0] op_size = '0;
  logic [31:0] sr1 = '0, sr2 = '0, esp = '0, eip = '0, ecx = '0;
  logic in_ready, out_valid, out_last, out_nop, out_err;
  logic [31:0] alu_res2, alu_res2_b, ecx_out;
  int cyc = 0, n_chk = 0, n_fail = 0;

  typedef struct {
    logic [3:0] op; logic [1:0] size; logic df;
    logic [31:0] sr1, sr2, esp, eip, ecx, res; logic err;
  } vec_t;
  typedef struct {
    logic [31:0] res, b, cnt; logic last, nop, err; int cyc;
  } beat_t;
  vec_t tbl[$];
  beat_t sb[$];

  alu2_seq #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu2_op(alu2_op), .op_size(op_size), .DF_in(df), .sr1(sr1), .sr2(sr2), .esp(esp),
    .EIP_next(eip), .ecx(ecx), .out_valid(out_valid), .out_ready(out_ready),
    .alu_res2(alu_res2), .alu_res2_b(alu_res2_b), .ecx_out(ecx_out),
    .out_last(out_last), .out_nop(out_nop), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [1:0] size, input logic d,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                     input logic [31:0] e, input logic [31:0] c, input logic [31:0] res,
                     input logic err);
    vec_t v;
    v.op = op; v.size = size; v.df = d; v.sr1 = a; v.sr2 = b; v.esp = s; v.eip = e;
    v.ecx = c; v.res = res; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic push_beat(input logic [31:0] res, input logic [31:0] b, input logic [31:0] cnt,
                           input logic last, input logic nop, input logic err, input int c);
    beat_t t;
    t.res = res; t.b = b; t.cnt = cnt; t.last = last; t.nop = nop; t.err = err; t.cyc = c;
    sb.push_back(t);
  endtask

  function automatic logic [31:0] bsz(input logic [1:0] s);
    return s == 2'b00 ? 32'd1 : s == 2'b01 ? 32'd2 : 32'd4;
  endfunction

  task automatic drive(input vec_t v);
    alu2_op = v.op; op_size = v.size; df = v.df; sr1 = v.sr1; sr2 = v.sr2;
    esp = v.esp; eip = v.eip; ecx = v.ecx; in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int c;
    logic [31:0] s;
    @(negedge clk);
    drive(v);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    else begin
      c = cyc + 1;
      s = bsz(v.size);
      if (v.op == 4'b1001 && !v.err) begin
        if (v.ecx == 0) push_beat(v.sr2, v.sr1, 0, 1'b1, 1'b1, 1'b0, c);
        else for (int k = 1; k <= int'(v.ecx); k++)
          push_beat(v.df ? v.sr2 - s * 32'(k) : v.sr2 + s * 32'(k),
                    v.df ? v.sr1 - s * 32'(k) : v.sr1 + s * 32'(k),
                    v.ecx - 32'(k), k == int'(v.ecx), 1'b0, 1'b0, c + k - 1);
      end else push_beat(v.res, 0, 0, 1'b1, 1'b0, v.err, c);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected beat res=%h cnt=%h", alu_res2, ecx_out);
        end else begin
          e = sb.pop_front();
          if ({alu_res2, alu_res2_b, ecx_out, out_last, out_nop, out_err} !==
              {e.res, e.b, e.cnt, e.last, e.nop, e.err} || (e.cyc != 0 && cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL beat: got res=%h b=%h cnt=%h last=%b nop=%b err=%b cyc=%0d expected res=%h b=%h cnt=%h last=%b nop=%b err=%b cyc=%0d",
                     alu_res2, alu_res2_b, ecx_out, out_last, out_nop, out_err, cyc,
                     e.res, e.b, e.cnt, e.last, e.nop, e.err, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    add(4'b0000, 2'b10, 1'b0, 32'h11223344, 32'h5, 32'h6, 32'h7, 0, 32'h11223344, 1'b0);
    add(4'b0001, 2'b10, 1'b0, 32'h1, 32'hDEADBEEF, 32'h6, 32'h7, 0, 32'hDEADBEEF, 1'b0);
    add(4'b0010, 2'b10, 1'b0, 32'h1, 32'h2, 32'h6, 32'h00401000, 0, 32'h00401000, 1'b0);
    add(4'b0100, 2'b00, 1'b0, 32'h1, 32'h2, 32'h1000, 32'h7, 0, 32'h1001, 1'b0);
    add(4'b0100, 2'b10, 1'b1, 32'h1, 32'h2, 32'h1000, 32'h7, 0, 32'h1004, 1'b0);
    add(4'b0110, 2'b01, 1'b0, 32'h1, 32'h2, 32'h1000, 32'h7, 0, 32'h0FFE, 1'b0);
    add(4'b0110, 2'b11, 1'b0, 32'h1, 32'h2, 32'h0, 32'h7, 0, 32'hFFFFFFFC, 1'b0);
    add(4'b0101, 2'b10, 1'b1, 32'h1, 32'h0, 32'h9, 32'h7, 0, 32'hFFFFFFFC, 1'b0);
    add(4'b0101, 2'b00, 1'b0, 32'h1, 32'hFFFFFFFF, 32'h9, 32'h7, 0, 32'h0, 1'b0);
    add(4'b0101, 2'b01, 1'b1, 32'h1, 32'h100, 32'h9, 32'h7, 0, 32'hFE, 1'b0);
    add(4'b1000, 2'b00, 1'b0, 32'h1, 32'h10, 32'h2000, 32'h7, 0, 32'h2014, 1'b0);
    add(4'b0111, 2'b10, 1'b0, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 3, 32'h0, 1'b1);
    add(4'b0011, 2'b10, 1'b0, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 3, 32'h0, 1'b1);
    add(4'b1111, 2'b00, 1'b1, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 3, 32'h0, 1'b1);
`ifndef ALU2_REP_EN
    add(4'b1001, 2'b10, 1'b0, 32'h100, 32'h200, 32'hCC, 32'hDD, 3, 32'h0, 1'b1);
`endif
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_res", alu_res2, 0);
    chk("rst_res_b", alu_res2_b, 0);
    chk("rst_ecx_out", ecx_out, 0);
    chk("rst_flags", {29'd0, out_last, out_nop, out_err}, 0);
    foreach (tbl[i]) send(tbl[i]);
`ifdef ALU2_REP_EN
    add(4'b1001, 2'b10, 1'b0, 32'h100, 32'h200, 0, 0, 3, 0, 1'b0);
    send(tbl[tbl.size() - 1]);
    repeat (3) begin
      @(negedge clk);
      chk("rep_in_ready_low", {31'd0, in_ready}, 0);
    end
    add(4'b1001, 2'b10, 1'b0, 32'h100, 32'h200, 0, 0, 0, 0, 1'b0);
    send(tbl[tbl.size() - 1]);
    @(negedge clk);
    chk("rep0_in_ready", {31'd0, in_ready}, 1);
    add(4'b1001, 2'b01, 1'b1, 32'h100, 32'h200, 0, 0, 5, 0, 1'b0);
    v = tbl[tbl.size() - 1];
    drive(v);
    push_beat(32'h1FE, 32'hFE, 4, 1'b0, 1'b0, 1'b0, 0);
    push_beat(32'h1FC, 32'hFC, 3, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_res", alu_res2, 32'h1FE);
      chk("stall_res_b", alu_res2_b, 32'hFE);
      chk("stall_cnt", ecx_out, 4);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("beat3_res", alu_res2, 32'h1FA);
    chk("beat3_cnt", ecx_out, 2);
    @(posedge clk);
    #1 flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_in_ready", {31'd0, in_ready}, 1);
    chk("flush_sb_empty", sb.size(), 0);
    add(4'b1001, 2'b10, 1'b0, 32'h100, 32'h200, 0, 0, 10, 0, 1'b0);
`else
    add(4'b0110, 2'b10, 1'b0, 32'h1, 32'h2, 32'h1000, 32'h7, 0, 32'h0FFC, 1'b0);
`endif
    v = tbl[tbl.size() - 1];
    @(negedge clk);
    drive(v);
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #1 rst = 1'b1;
    #1 chk("async_rst_valid", {31'd0, out_valid}, 0);
    chk("async_rst_res", alu_res2, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    send(tbl[5]);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
